// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter on the DW8051 SFR bus: leader, 32 data bits LSB-first
// (addr, ~addr, cmd, ~cmd) or repeat code, with a carrier-modulated LED drive.
module nec_ir_tx #(
  parameter int         UNIT_CYC = 28125,
  parameter int         CAR_HALF = 658,
  parameter logic [7:0] A_ADDR   = 8'hC1,
  parameter logic [7:0] A_CMD    = 8'hC2,
  parameter logic [7:0] A_CTRL   = 8'hC3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  input  logic       sfr_wr,
  input  logic       sfr_rd,
  output logic [7:0] sfr_rdata,
  output logic       sfr_hit,
  output logic       ir_tx,
  output logic       ir_env,
  output logic       busy
);

  localparam int UW = $clog2(UNIT_CYC + 1);
  localparam int CW = $clog2(CAR_HALF + 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
  } state_t;

  state_t        state;
  logic [7:0]    addr_r, cmd_r;
  logic          done, rpt;
  logic [31:0]   shreg;
  logic [4:0]    bit_idx, units, state_len;
  logic [UW-1:0] unit_cnt;
  logic [CW-1:0] car_cnt;
  logic          unit_end, ctrl_wr, unused_rd;

  assign unused_rd = sfr_rd;
  assign ctrl_wr   = sfr_wr && (sfr_addr == A_CTRL);
  assign unit_end  = (unit_cnt == UW'(UNIT_CYC - 1));

  always_comb begin
    state_len = 5'd1;
    case (state)
      LEAD_MARK:  state_len = 5'd16;
      LEAD_SPACE: state_len = rpt ? 5'd4 : 5'd8;
      BIT_SPACE:  state_len = shreg[0] ? 5'd3 : 5'd1;
      default:    state_len = 5'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_r   <= '0;
      cmd_r    <= '0;
      done     <= 1'b0;
      rpt      <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      units    <= '0;
      unit_cnt <= '0;
      car_cnt  <= '0;
      busy     <= 1'b0;
      ir_env   <= 1'b0;
      ir_tx    <= 1'b0;
    end else begin
      if (sfr_wr && sfr_addr == A_ADDR) addr_r <= sfr_wdata;
      if (sfr_wr && sfr_addr == A_CMD)  cmd_r  <= sfr_wdata;

      if (state == IDLE) begin
        if (ctrl_wr && (sfr_wdata[0] || sfr_wdata[1])) begin
          state    <= LEAD_MARK;
          rpt      <= ~sfr_wdata[0];
          shreg    <= {~cmd_r, cmd_r, ~addr_r, addr_r};
          bit_idx  <= '0;
          units    <= '0;
          unit_cnt <= '0;
          car_cnt  <= '0;
          busy     <= 1'b1;
          ir_env   <= 1'b1;
          ir_tx    <= 1'b1;
        end
      end else begin
        if (ir_env) begin
          if (car_cnt == CW'(CAR_HALF - 1)) begin
            car_cnt <= '0;
            ir_tx   <= ~ir_tx;
          end else begin
            car_cnt <= car_cnt + CW'(1);
          end
        end

        if (!unit_end) begin
          unit_cnt <= unit_cnt + UW'(1);
        end else begin
          unit_cnt <= '0;
          units    <= units + 5'd1;
          if (units == state_len - 5'd1) begin
            // Transition assignments below override the carrier update above.
            units <= '0;
            case (state)
              LEAD_MARK: begin
                state  <= LEAD_SPACE;
                ir_env <= 1'b0;
                ir_tx  <= 1'b0;
              end
              LEAD_SPACE: begin
                state   <= rpt ? STOP_MARK : BIT_MARK;
                ir_env  <= 1'b1;
                ir_tx   <= 1'b1;
                car_cnt <= '0;
              end
              BIT_MARK: begin
                state  <= BIT_SPACE;
                ir_env <= 1'b0;
                ir_tx  <= 1'b0;
              end
              BIT_SPACE: begin
                shreg   <= shreg >> 1;
                state   <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                bit_idx <= bit_idx + 5'd1;
                ir_env  <= 1'b1;
                ir_tx   <= 1'b1;
                car_cnt <= '0;
              end
              default: begin
                state   <= IDLE;
                busy    <= 1'b0;
                ir_env  <= 1'b0;
                ir_tx   <= 1'b0;
                car_cnt <= '0;
                done    <= 1'b1;
              end
            endcase
          end
        end
      end

      if (ctrl_wr) done <= 1'b0;
    end
  end

  always_comb begin
    sfr_rdata = '0;
    sfr_hit   = 1'b0;
    if (sfr_addr == A_ADDR) begin
      sfr_rdata = addr_r;
      sfr_hit   = 1'b1;
    end else if (sfr_addr == A_CMD) begin
      sfr_rdata = cmd_r;
      sfr_hit   = 1'b1;
    end else if (sfr_addr == A_CTRL) begin
      sfr_rdata = {busy, done, 6'b0};
      sfr_hit   = 1'b1;
    end
  end

endmodule

// File: doc/nec_ir_tx.md
# nec_ir_tx

SFR-mapped NEC infrared transmitter for the DW8051 system; the transmit-side counterpart of the IR receive path in the IR SFR block. Firmware writes an 8-bit address and an 8-bit command, then launches a frame. The block generates the NEC envelope (leader, 32 data bits LSB-first as addr, ~addr, cmd, ~cmd, stop mark) or a repeat code, and modulates marks with a 38 kHz carrier to drive an IR LED. It sits beside the IR SFR block on the core's SFR bus; its read data is OR-merged into the core's SFR input.

## Interface
- UNIT_CYC, 28125: clock cycles per 562.5 us NEC unit at 50 MHz.
- CAR_HALF, 658: clock cycles per carrier half-period (~38 kHz).
- A_ADDR, 8'hC1: SFR address of the ADDR register (R/W).
- A_CMD, 8'hC2: SFR address of the CMD register (R/W).
- A_CTRL, 8'hC3: SFR address of the CTRL register.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst_n  in  1  synchronous, active-low reset.
- sfr_addr  in  8  SFR address from core.
- sfr_wdata  in  8  SFR write data (core sfr_data_out).
- sfr_wr  in  1  SFR write strobe, one cycle.
- sfr_rd  in  1  SFR read strobe (no side effects; accepted, unused).
- sfr_rdata  out  8  register value when sfr_addr hits, else 0 (combinational).
- sfr_hit  out  1  sfr_addr equals A_ADDR, A_CMD or A_CTRL (combinational).
- ir_tx  out  1  modulated LED drive, active high.
- ir_env  out  1  unmodulated envelope, 1 during marks.
- busy  out  1  frame in progress.

## Operation
- CTRL write: bit0 START launches full frame; bit1 REPEAT launches repeat code; START wins if both set. Ignored while busy (no queueing). Any CTRL write clears DONE.
- CTRL read: bit7 BUSY, bit6 DONE (sticky, set when a frame ends), other bits 0.
- ADDR/CMD writable anytime; on launch they are copied into a 32-bit shift register {~cmd, cmd, ~addr, addr}, so writes during busy never affect the frame in flight.
- FSM states: IDLE, LEAD_MARK (16 units), LEAD_SPACE (8 units full / 4 units repeat), BIT_MARK (1 unit), BIT_SPACE (1 unit for 0, 3 units for 1), STOP_MARK (1 unit), then IDLE.
- Full frame: IDLE -> LEAD_MARK -> LEAD_SPACE -> 32 x (BIT_MARK -> BIT_SPACE), bit index 0..31, LSB first -> STOP_MARK -> IDLE.
- Repeat frame: IDLE -> LEAD_MARK -> LEAD_SPACE(4) -> STOP_MARK -> IDLE.
- Unit counter counts 0..UNIT_CYC-1 and drives a per-state unit count. Bit counter is 5 bits; exit after index 31.
- Carrier: during marks, ir_tx starts at 1 on the first mark cycle and toggles every CAR_HALF cycles. The carrier counter restarts at every mark start. During spaces and idle, ir_tx = 0.
- ir_env = 1 exactly in LEAD_MARK, BIT_MARK, STOP_MARK.

## Timing
- Reset (rst_n low at a clk edge): FSM IDLE, ADDR = CMD = 0, DONE = 0, busy = 0, ir_tx = 0, ir_env = 0, all counters 0. Reset mid-frame aborts at the next edge with no stop mark, and DONE stays 0.
- Launch: a START write sampled at edge N gives busy = ir_env = ir_tx = 1 from cycle N+1.
- Full frame length is always 121 x UNIT_CYC cycles, because the complement bytes guarantee 16 ones and 16 zeros: 16 + 8 + 16x2 + 16x4 + 1.
- Repeat frame length is 21 x UNIT_CYC cycles.
- At the last cycle of STOP_MARK, the next edge gives busy = 0, ir_env = 0, ir_tx = 0, DONE = 1. A START sampled on that same edge is ignored, because busy was still 1.
- A CTRL write with START on the edge where DONE would set: DONE is cleared and no frame starts (busy was 1).
- sfr_rdata and sfr_hit reflect register state combinationally. The BUSY bit equals the busy output.

## Test plan
- UNIT_CYC = 8, CAR_HALF = 2. Reset with outputs probed -> all outputs 0. Read CTRL -> 8'h00; read ADDR/CMD -> 0. Read at address 8'h80 -> sfr_hit = 0, sfr_rdata = 0.
- ADDR = 8'h00, CMD = 8'hA5, CTRL = 8'h01 -> busy for exactly 968 cycles. ir_env mark/space widths: 128/64, then per bit 8/8 or 8/24 per pattern {5A,A5,FF,00} LSB-first, then 8 final mark. DONE = 1 afterwards.
- During a mark, ir_tx toggles every 2 cycles starting high; during every space, ir_tx = 0.
- CTRL = 8'h02 -> ir_env 128 high, 32 low, 8 high. busy lasts 168 cycles.
- While busy, write CTRL = 8'h01 and ADDR = 8'hFF -> current frame unchanged and no second frame. The next START sends addr FF.
- Assert rst_n low at mid bit 10 -> at the next edge busy = ir_tx = ir_env = 0 and DONE = 0. A new START after release produces a full correct frame.
